// File: rtl/fec_viterbi_decoder.sv
// Hard-decision Viterbi decoder for the rate-1/2 K=7 tail-biting code (G=133o/171o).
// Define FEC_DEC_ERRCNT_EN to expose the winning path metric of the last block on err_count.
module fec_viterbi_decoder #(
  parameter int BLOCK_BITS = 96,
  parameter int METRIC_W   = 8
) (
  input  logic clk_100MHz,
  input  logic rst_n,
  input  logic data_in,
  input  logic valid_in,
  output logic ready_out,
  output logic data_out,
  output logic valid_out
`ifdef FEC_DEC_ERRCNT_EN
  ,
  output logic [METRIC_W-1:0] err_count
`endif
);
  localparam int CW = $clog2(BLOCK_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_BITS - 1);

  typedef logic [METRIC_W-1:0] metric_t;
  typedef enum logic [1:0] {S_IDLE, S_ACS, S_TRACEBACK, S_OUTPUT} state_t;

  state_t                state_q, state_d;
  logic                  ready_q, ready_d, valid_q, valid_d, dout_q, dout_d;
  logic                  phase_q, phase_d, first_q, first_d, go_q, go_d;
  logic [1:0]            pair_q, pair_d;
  logic [CW-1:0]         pair_cnt_q, pair_cnt_d, acs_t_q, acs_t_d;
  logic [CW-1:0]         tb_t_q, tb_t_d, out_idx_q, out_idx_d;
  logic [5:0]            tb_s_q, tb_s_d, tb_cur_s, min_st_s;
  logic [BLOCK_BITS-1:0] dec_q, dec_d;
  metric_t               pm_q [64];
  metric_t               pm_new_s [64];
  metric_t               m0_s [64];
  metric_t               m1_s [64];
  metric_t               min_val_s;
  logic [63:0]           surv_new_s;
  logic [63:0]           surv_q [BLOCK_BITS];
  logic                  acc_s, clear_s;

  // Hamming distance between the received pair {C0,C1} and the branch leaving p with input u.
  function automatic logic [1:0] branch_bm(input logic [5:0] p, input logic u, input logic [1:0] rx);
    logic c0, c1;
    c0 = u ^ p[4] ^ p[3] ^ p[1] ^ p[0];
    c1 = u ^ p[5] ^ p[4] ^ p[3] ^ p[0];
    return {1'b0, c0 ^ rx[1]} + {1'b0, c1 ^ rx[0]};
  endfunction

  // Add-compare-select for all 64 states; ties keep the predecessor whose dropped bit is 0.
  always_comb begin
    surv_new_s = 64'd0;
    for (int sp = 0; sp < 64; sp++) begin
      m0_s[sp] = pm_q[{sp[4:0], 1'b0}] + metric_t'(branch_bm({sp[4:0], 1'b0}, sp[5], pair_q));
      m1_s[sp] = pm_q[{sp[4:0], 1'b1}] + metric_t'(branch_bm({sp[4:0], 1'b1}, sp[5], pair_q));
      surv_new_s[sp] = (m1_s[sp] < m0_s[sp]);
      pm_new_s[sp]   = surv_new_s[sp] ? m1_s[sp] : m0_s[sp];
    end
  end

  // Minimum-metric state search, lowest index wins on ties.
  always_comb begin
    min_val_s = pm_q[0];
    min_st_s  = 6'd0;
    for (int i = 1; i < 64; i++) begin
      min_st_s  = (pm_q[i] < min_val_s) ? 6'(i) : min_st_s;
      min_val_s = (pm_q[i] < min_val_s) ? pm_q[i] : min_val_s;
    end
  end

  assign acc_s    = valid_in && ready_q;
  assign clear_s  = (state_q == S_OUTPUT) && (out_idx_q == LAST);
  assign tb_cur_s = (tb_t_q == LAST) ? min_st_s : tb_s_q;

  // Next-state and output logic for input pairing, traceback and serial output.
  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    valid_d    = valid_q;
    dout_d     = dout_q;
    phase_d    = phase_q;
    first_d    = first_q;
    pair_d     = pair_q;
    go_d       = 1'b0;
    pair_cnt_d = pair_cnt_q;
    acs_t_d    = acs_t_q;
    tb_t_d     = tb_t_q;
    tb_s_d     = tb_s_q;
    out_idx_d  = out_idx_q;
    dec_d      = dec_q;
    if (acc_s) begin
      if (!phase_q) begin
        first_d = data_in;
        phase_d = 1'b1;
      end else begin
        pair_d     = {first_q, data_in};
        phase_d    = 1'b0;
        go_d       = 1'b1;
        acs_t_d    = pair_cnt_q;
        pair_cnt_d = pair_cnt_q + CW'(1);
        ready_d    = (pair_cnt_q == LAST) ? 1'b0 : ready_q;
      end
    end else begin
      go_d = 1'b0;
    end
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        state_d = acc_s ? S_ACS : S_IDLE;
      end
      S_ACS: begin
        if (go_q && (acs_t_q == LAST)) begin
          state_d = S_TRACEBACK;
          tb_t_d  = LAST;
        end else begin
          state_d = S_ACS;
        end
      end
      S_TRACEBACK: begin
        dec_d[tb_t_q] = tb_cur_s[5];
        tb_s_d        = {tb_cur_s[4:0], surv_q[tb_t_q][tb_cur_s]};
        if (tb_t_q == CW'(0)) begin
          state_d   = S_OUTPUT;
          valid_d   = 1'b1;
          dout_d    = tb_cur_s[5];
          out_idx_d = CW'(0);
        end else begin
          tb_t_d = tb_t_q - CW'(1);
        end
      end
      S_OUTPUT: begin
        if (out_idx_q == LAST) begin
          state_d    = S_IDLE;
          valid_d    = 1'b0;
          dout_d     = 1'b0;
          ready_d    = 1'b1;
          pair_cnt_d = CW'(0);
          phase_d    = 1'b0;
        end else begin
          out_idx_d = out_idx_q + CW'(1);
          valid_d   = 1'b1;
          dout_d    = dec_q[out_idx_q + CW'(1)];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      dout_q     <= 1'b0;
      phase_q    <= 1'b0;
      first_q    <= 1'b0;
      pair_q     <= 2'd0;
      go_q       <= 1'b0;
      pair_cnt_q <= CW'(0);
      acs_t_q    <= CW'(0);
      tb_t_q     <= CW'(0);
      tb_s_q     <= 6'd0;
      out_idx_q  <= CW'(0);
      dec_q      <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      dout_q     <= dout_d;
      phase_q    <= phase_d;
      first_q    <= first_d;
      pair_q     <= pair_d;
      go_q       <= go_d;
      pair_cnt_q <= pair_cnt_d;
      acs_t_q    <= acs_t_d;
      tb_t_q     <= tb_t_d;
      tb_s_q     <= tb_s_d;
      out_idx_q  <= out_idx_d;
      dec_q      <= dec_d;
    end
  end

  // Path metrics: zero at every block start, updated once per received pair.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) pm_q[i] <= metric_t'(0);
    end else if (clear_s) begin
      for (int i = 0; i < 64; i++) pm_q[i] <= metric_t'(0);
    end else if (go_q) begin
      for (int i = 0; i < 64; i++) pm_q[i] <= pm_new_s[i];
    end
  end

  // Survivor memory, one 64-bit row per trellis step.
  always_ff @(posedge clk_100MHz) begin
    if (go_q) surv_q[acs_t_q] <= surv_new_s;
  end

`ifdef FEC_DEC_ERRCNT_EN
  logic [METRIC_W-1:0] errc_q;
  // Winning metric captured on the first traceback cycle.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) errc_q <= metric_t'(0);
    else if ((state_q == S_TRACEBACK) && (tb_t_q == LAST)) errc_q <= min_val_s;
  end
  assign err_count = errc_q;
`endif

  assign ready_out = ready_q;
  assign valid_out = valid_q;
  assign data_out  = dout_q;
endmodule
